// File: rtl/apb_regbank_param_if.sv
// apb_regbank_param_if: APB4 bus bundle between a master and the register bank
interface apb_regbank_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]   paddr;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic [DATA_W-1:0]   prdata;
  logic                pready;
  logic                pslverr;
  modport master (output paddr, psel, penable, pwrite, pwdata, pstrb, input prdata, pready, pslverr);
  modport slave (input paddr, psel, penable, pwrite, pwdata, pstrb, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_regbank_param.sv
// apb_regbank_param: APB4 register bank with lockable DATA regs, CTRL lock and STATUS counters
module apb_regbank_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NUM_REGS = 4,
  parameter int WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                       pclk,
  input  logic                       presetn,
  apb_regbank_param_if.slave         apb,
  output logic [NUM_REGS-1:0]        lock_o,
  output logic [NUM_REGS*DATA_W-1:0] data_o
);
  localparam int S = DATA_W / 8;
  localparam int LSB = $clog2(S);
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state_q, state_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic pready_q, pready_d, pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic err_q, err_d, wr_q, wr_d, csel_q, csel_d, ssel_q, ssel_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rd_q, rd_d;
  logic [S-1:0] strb_q, strb_d;
  logic [NUM_REGS-1:0] ctrl_q, ctrl_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] data_q, data_d;
  logic [15:0] wr_cnt_q, wr_cnt_d, err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] word;
  logic [IW-1:0] didx;
  logic is_ctrl, is_stat, dec_err, fire;
  logic [DATA_W-1:0] dec_rd;
  assign lock_o = ctrl_q;
  assign data_o = data_q;
  assign apb.pready = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata = prdata_q;
  always_comb begin
    word = apb.paddr >> LSB;
    didx = IW'(word - ADDR_W'(1));
    is_ctrl = word == '0;
    is_stat = word == ADDR_W'(NUM_REGS + 1);
    dec_err = (|apb.paddr[LSB-1:0]) || word > ADDR_W'(NUM_REGS + 1)
              || (apb.pwrite && !is_ctrl && !is_stat && ctrl_q[didx]);
    dec_rd = is_ctrl ? DATA_W'(ctrl_q) : is_stat ? DATA_W'({err_cnt_q, wr_cnt_q}) : data_q[didx];
  end
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    err_d = err_q;
    wr_d = wr_q;
    csel_d = csel_q;
    ssel_d = ssel_q;
    idx_d = idx_q;
    wdata_d = wdata_q;
    strb_d = strb_q;
    rd_d = rd_q;
    ctrl_d = ctrl_q;
    data_d = data_q;
    wr_cnt_d = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    fire = 1'b0;
    if (state_q == IDLE) begin
      if (apb.psel && !apb.penable) begin
        state_d = ACCESS;
        wcnt_d = 3'(WAIT_STATES);
        err_d = dec_err;
        wr_d = apb.pwrite;
        csel_d = is_ctrl;
        ssel_d = is_stat;
        idx_d = didx;
        wdata_d = apb.pwdata;
        strb_d = apb.pstrb;
        rd_d = dec_rd;
        fire = WAIT_STATES == 0;
      end
    end else if (!apb.psel) begin
      state_d = IDLE;
    end else if (pready_q) begin
      // completion edge: the only place architectural state changes
      state_d = IDLE;
      if (err_q) begin
        err_cnt_d = err_cnt_q + {15'd0, err_cnt_q != 16'hFFFF};
      end else if (wr_q && ssel_q) begin
        wr_cnt_d = '0;
        err_cnt_d = '0;
      end else if (wr_q) begin
        wr_cnt_d = wr_cnt_q + {15'd0, wr_cnt_q != 16'hFFFF};
        if (csel_q) ctrl_d = strb_q[0] ? wdata_q[NUM_REGS-1:0] : ctrl_q;
        else for (int k = 0; k < S; k++) if (strb_q[k]) data_d[idx_q][8*k +: 8] = wdata_q[8*k +: 8];
      end
    end else begin
      wcnt_d = wcnt_q - 3'd1;
      fire = wcnt_q == 3'd1;
    end
    pready_d = fire;
    pslverr_d = fire && err_d;
    prdata_d = (fire && !err_d && !wr_d) ? rd_d : '0;
  end
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      wcnt_q <= '0;
      pready_q <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q <= '0;
      err_q <= 1'b0;
      wr_q <= 1'b0;
      csel_q <= 1'b0;
      ssel_q <= 1'b0;
      idx_q <= '0;
      wdata_q <= '0;
      strb_q <= '0;
      rd_q <= '0;
      ctrl_q <= '0;
      data_q <= {NUM_REGS{RST_VAL}};
      wr_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      pready_q <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q <= prdata_d;
      err_q <= err_d;
      wr_q <= wr_d;
      csel_q <= csel_d;
      ssel_q <= ssel_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      strb_q <= strb_d;
      rd_q <= rd_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      wr_cnt_q <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule
